// File: rtl/operand_fetch.sv
// Register-file read stage: 32-entry register file, three source operands plus the
// immediate, registered one cycle later, with writeback bypass and a pending-result scoreboard.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int IMM_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_ra_i,
    input  logic [ADDR_WIDTH-1:0] addr_rb_i,
    input  logic [ADDR_WIDTH-1:0] addr_rc_i,
    input  logic                  use_ra_i,
    input  logic                  use_rb_i,
    input  logic                  use_rc_i,
    input  logic                  dst_en_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [IMM_WIDTH-1:0]  imm_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  wb_en_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  hazard_o,
    output logic [DATA_WIDTH-1:0] data_ra_o,
    output logic [DATA_WIDTH-1:0] data_rb_o,
    output logic [DATA_WIDTH-1:0] data_rc_o,
    output logic [IMM_WIDTH-1:0]  data_imm_o,
    output logic                  valid_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_reg;
    logic [NUM_REGS-1:0]   pending_next;
    logic [NUM_REGS-1:0]   wb_clear;
    logic [NUM_REGS-1:0]   pending_eff;
    logic                  out_dst_en_reg;
    logic [ADDR_WIDTH-1:0] out_dst_addr_reg;
    logic                  raw;
    logic                  waw;
    logic                  accept;

    // Operand read with write-first bypass; r0 is hard-wired to zero.
    function automatic logic [DATA_WIDTH-1:0] read_op(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else if (wb_en_i && (wb_addr_i == addr)) begin
            value = wb_data_i;
        end else begin
            value = regs[addr];
        end
        return value;
    endfunction

    always_comb begin
        wb_clear = '0;
        if (wb_en_i) begin
            wb_clear[wb_addr_i] = 1'b1;
        end
    end

    // A same-cycle writeback releases the register before the hazard check.
    assign pending_eff = pending_reg & ~wb_clear;

    assign raw = (use_ra_i & pending_eff[addr_ra_i])
               | (use_rb_i & pending_eff[addr_rb_i])
               | (use_rc_i & pending_eff[addr_rc_i]);
    assign waw = dst_en_i & pending_eff[dst_addr_i];

    assign hazard_o = in_valid_i & (raw | waw);
    assign accept   = in_valid_i & ~hazard_o & ~stall_i & ~flush_i;

    always_comb begin
        pending_next = pending_reg & ~wb_clear;
        // A flushed output instruction will never write back, so release its destination.
        if (flush_i && valid_o && out_dst_en_reg && (out_dst_addr_reg != '0)) begin
            pending_next[out_dst_addr_reg] = 1'b0;
        end
        if (accept && dst_en_i && (dst_addr_i != '0)) begin
            pending_next[dst_addr_i] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_i && (wb_addr_i != '0)) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_ra_o        <= '0;
            data_rb_o        <= '0;
            data_rc_o        <= '0;
            data_imm_o       <= '0;
            valid_o          <= 1'b0;
            out_dst_en_reg   <= 1'b0;
            out_dst_addr_reg <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (stall_i) begin
            valid_o <= valid_o;
        end else if (accept) begin
            data_ra_o        <= read_op(addr_ra_i);
            data_rb_o        <= read_op(addr_rb_i);
            data_rc_o        <= read_op(addr_rc_i);
            data_imm_o       <= imm_i;
            valid_o          <= 1'b1;
            out_dst_en_reg   <= dst_en_i;
            out_dst_addr_reg <= dst_addr_i;
        end else begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed vector bench for operand_fetch: table of per-cycle stimulus with expected
// hazard/valid/operand values, plus an asynchronous-reset-mid-hazard sequence.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  addr_ra, addr_rb, addr_rc;
    logic        use_ra, use_rb, use_rc;
    logic        dst_en;
    logic [4:0]  dst_addr;
    logic [15:0] imm;
    logic        stall, flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hazard;
    logic [31:0] data_ra, data_rb, data_rc;
    logic [15:0] data_imm;
    logic        valid;

    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .addr_ra_i  (addr_ra),
        .addr_rb_i  (addr_rb),
        .addr_rc_i  (addr_rc),
        .use_ra_i   (use_ra),
        .use_rb_i   (use_rb),
        .use_rc_i   (use_rc),
        .dst_en_i   (dst_en),
        .dst_addr_i (dst_addr),
        .imm_i      (imm),
        .stall_i    (stall),
        .flush_i    (flush),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .hazard_o   (hazard),
        .data_ra_o  (data_ra),
        .data_rb_o  (data_rb),
        .data_rc_o  (data_rc),
        .data_imm_o (data_imm),
        .valid_o    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [2:0]  use_abc;
        logic [4:0]  ra, rb, rc;
        logic        de;
        logic [4:0]  da;
        logic [15:0] im;
        logic        st, fl;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ehz, ev, cd;
        logic [31:0] era, erb, erc;
        logic [15:0] eimm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = v.iv;
        {use_ra, use_rb, use_rc} = v.use_abc;
        addr_ra  = v.ra;
        addr_rb  = v.rb;
        addr_rc  = v.rc;
        dst_en   = v.de;
        dst_addr = v.da;
        imm      = v.im;
        stall    = v.st;
        flush    = v.fl;
        wb_en    = v.we;
        wb_addr  = v.wa;
        wb_data  = v.wd;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("v%0d_hazard", idx), {31'd0, hazard}, {31'd0, v.ehz});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid", idx), {31'd0, valid}, {31'd0, v.ev});
        if (v.cd) begin
            chk($sformatf("v%0d_ra", idx), data_ra, v.era);
            chk($sformatf("v%0d_rb", idx), data_rb, v.erb);
            chk($sformatf("v%0d_rc", idx), data_rc, v.erc);
            chk($sformatf("v%0d_imm", idx), {16'd0, data_imm}, {16'd0, v.eimm});
        end
        $display("vec %0d: hazard=%0b valid=%0b ra=%h rb=%h rc=%h imm=%h",
                 idx, hazard, valid, data_ra, data_rb, data_rc, data_imm);
    endtask

    initial begin
        vec_t idle;
        idle = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0};
        rst = 1'b1;
        drive(idle);

        //         iv  use    ra  rb  rc  de da imm       st fl we wa  wd             hz v cd era           erb           erc           imm
        // write r5, then read it back one cycle later
        vecs.push_back('{1'b0, 3'b000, 5'd0,  5'd0, 5'd0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 5'd5,  32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        vecs.push_back('{1'b1, 3'b111, 5'd5,  5'd0, 5'd5, 1'b0, 5'd0,  16'h1111, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h12345678, 32'h0, 32'h12345678, 16'h1111});
        // bypass of same-cycle writeback
        vecs.push_back('{1'b1, 3'b110, 5'd7,  5'd5, 5'd0, 1'b0, 5'd0,  16'h2222, 1'b0, 1'b0, 1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0, 16'h2222});
        // dst=r3, then RAW hazard on rb=r3, released by wb r3=0x55 with bypass
        vecs.push_back('{1'b1, 3'b100, 5'd7,  5'd0, 5'd0, 1'b1, 5'd3,  16'h0003, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 16'h0003});
        vecs.push_back('{1'b1, 3'b010, 5'd0,  5'd3, 5'd0, 1'b0, 5'd0,  16'h0004, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        vecs.push_back('{1'b1, 3'b010, 5'd0,  5'd3, 5'd0, 1'b0, 5'd0,  16'h0004, 1'b0, 1'b0, 1'b1, 5'd3,  32'h00000055, 1'b0, 1'b1, 1'b1, 32'h0, 32'h55, 32'h0, 16'h0004});
        // WAW on r4; an unused source on a pending register is harmless
        vecs.push_back('{1'b1, 3'b000, 5'd0,  5'd0, 5'd0, 1'b1, 5'd4,  16'h0006, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0006});
        vecs.push_back('{1'b1, 3'b000, 5'd0,  5'd0, 5'd0, 1'b1, 5'd4,  16'h0007, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        vecs.push_back('{1'b1, 3'b000, 5'd4,  5'd0, 5'd0, 1'b0, 5'd0,  16'h0008, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0008});
        vecs.push_back('{1'b0, 3'b000, 5'd0,  5'd0, 5'd0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 5'd4,  32'h00000044, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        // stall hold: r10=0xA read, then 3 stalled cycles while r10 is rewritten
        vecs.push_back('{1'b0, 3'b000, 5'd0,  5'd0, 5'd0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0000000A, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        vecs.push_back('{1'b1, 3'b100, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0,  16'h000B, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'hA, 32'h0, 32'h0, 16'h000B});
        for (int k = 0; k < 3; k++)
            vecs.push_back('{1'b1, 3'b100, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0,  16'h00CC, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000000B, 1'b0, 1'b1, 1'b1, 32'hA, 32'h0, 32'h0, 16'h000B});
        vecs.push_back('{1'b1, 3'b100, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0,  16'h00DD, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'hB, 32'h0, 32'h0, 16'h00DD});
        // flush of output instruction with dst=r9; writeback in flush cycle commits
        vecs.push_back('{1'b1, 3'b000, 5'd0,  5'd0, 5'd0, 1'b1, 5'd9,  16'h0010, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0010});
        vecs.push_back('{1'b1, 3'b100, 5'd9,  5'd0, 5'd0, 1'b0, 5'd0,  16'h0011, 1'b0, 1'b1, 1'b1, 5'd11, 32'h00000077, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        vecs.push_back('{1'b1, 3'b100, 5'd9,  5'd0, 5'd0, 1'b0, 5'd0,  16'h0012, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0012});
        vecs.push_back('{1'b1, 3'b100, 5'd11, 5'd0, 5'd0, 1'b0, 5'd0,  16'h0013, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h77, 32'h0, 32'h0, 16'h0013});
        // flush wins over stall
        vecs.push_back('{1'b1, 3'b100, 5'd11, 5'd0, 5'd0, 1'b0, 5'd0,  16'h0014, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        // r0: write ignored, never pending
        vecs.push_back('{1'b0, 3'b000, 5'd0,  5'd0, 5'd0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        vecs.push_back('{1'b1, 3'b111, 5'd0,  5'd0, 5'd0, 1'b1, 5'd0,  16'h0016, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0016});
        vecs.push_back('{1'b1, 3'b100, 5'd0,  5'd0, 5'd0, 1'b1, 5'd0,  16'h0017, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0017});
        // same-cycle set and clear of r12: set wins
        vecs.push_back('{1'b1, 3'b000, 5'd0,  5'd0, 5'd0, 1'b1, 5'd12, 16'h0018, 1'b0, 1'b0, 1'b1, 5'd12, 32'h00000012, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0018});
        vecs.push_back('{1'b1, 3'b100, 5'd12, 5'd0, 5'd0, 1'b0, 5'd0,  16'h0019, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0});
        vecs.push_back('{1'b1, 3'b100, 5'd12, 5'd0, 5'd0, 1'b0, 5'd0,  16'h001A, 1'b0, 1'b0, 1'b1, 5'd12, 32'h00000034, 1'b0, 1'b1, 1'b1, 32'h34, 32'h0, 32'h0, 16'h001A});
        // leave r13 pending with a valid output for the reset sequence
        vecs.push_back('{1'b1, 3'b000, 5'd0,  5'd0, 5'd0, 1'b1, 5'd13, 16'h001B, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 16'h001B});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_ra", data_ra, 32'd0);
        chk("reset_imm", {16'd0, data_imm}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_hazard", {31'd0, hazard}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // asynchronous reset while an instruction is blocked on r13
        @(negedge clk);
        drive(idle);
        in_valid = 1'b1;
        use_ra   = 1'b1;
        addr_ra  = 5'd13;
        use_rb   = 1'b1;
        addr_rb  = 5'd5;
        imm      = 16'h00EE;
        #1;
        chk("pre_rst_hazard", {31'd0, hazard}, 32'd1);
        chk("pre_rst_valid", {31'd0, valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_imm", {16'd0, data_imm}, 32'd0);
        chk("async_rst_hazard", {31'd0, hazard}, 32'd0);
        $display("async reset: hazard=%0b valid=%0b imm=%h", hazard, valid, data_imm);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_hazard", {31'd0, hazard}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, valid}, 32'd1);
        chk("post_rst_ra", data_ra, 32'd0);
        chk("post_rst_rb", data_rb, 32'd0);
        chk("post_rst_imm", {16'd0, data_imm}, 32'h00EE);
        $display("post reset issue: valid=%0b ra=%h rb=%h imm=%h", valid, data_ra, data_rb, data_imm);

        @(negedge clk);
        drive(idle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
